// File: rtl/mux16_arbiter_pkg.sv
// Shared definitions for the two-port Mux16 arbiter: FSM encodings, source
// constants and the saturating burst-counter helper.
package mux16_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

    localparam logic       SRC_A   = 1'b0;
    localparam logic       SRC_B   = 1'b1;
    localparam logic [7:0] CNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux16_arbiter_mux16.sv
// The existing 16-bit two-input multiplexer shared by both arbiter ports.
module mux16_arbiter_mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter with bounded bursts: two valid/ready producers share one
// Mux16 datapath feeding a registered valid/ready output stage.
module mux16_arbiter
    import mux16_arbiter_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_src,
    input  logic        out_ready
);

    localparam logic [7:0] BURST_C = BURST[7:0];

    arb_state_e  state_r;
    logic [7:0]  cnt_r;
    logic        last_r;
    logic        out_valid_r;
    logic [15:0] out_data_r;
    logic        out_src_r;

    logic        load_s;
    logic        sel_s;
    logic        xfer_s;
    logic        go_idle_s;
    logic        same_owner_s;
    logic [15:0] mux_y_s;

    assign load_s = !out_valid_r || out_ready;

    // Grant selection: the owner keeps the datapath until its burst is spent
    // while the other port waits; ties from IDLE alternate against last.
    always_comb begin
        sel_s     = last_r;
        xfer_s    = 1'b0;
        go_idle_s = 1'b0;
        if (load_s) begin
            case (state_r)
                IDLE: begin
                    if (a_valid && b_valid) begin
                        sel_s  = !last_r;
                        xfer_s = 1'b1;
                    end else if (a_valid) begin
                        sel_s  = SRC_A;
                        xfer_s = 1'b1;
                    end else if (b_valid) begin
                        sel_s  = SRC_B;
                        xfer_s = 1'b1;
                    end else begin
                        sel_s  = last_r;
                    end
                end
                OWN_A: begin
                    if (a_valid && ((cnt_r < BURST_C) || !b_valid)) begin
                        sel_s  = SRC_A;
                        xfer_s = 1'b1;
                    end else if (b_valid) begin
                        sel_s  = SRC_B;
                        xfer_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
                OWN_B: begin
                    if (b_valid && ((cnt_r < BURST_C) || !a_valid)) begin
                        sel_s  = SRC_B;
                        xfer_s = 1'b1;
                    end else if (a_valid) begin
                        sel_s  = SRC_A;
                        xfer_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
                default: begin
                    go_idle_s = 1'b1;
                end
            endcase
        end else begin
            sel_s = last_r;
        end
    end

    assign same_owner_s = ((sel_s == SRC_A) && (state_r == OWN_A)) ||
                          ((sel_s == SRC_B) && (state_r == OWN_B));

    assign a_ready = !reset && load_s && (sel_s == SRC_A);
    assign b_ready = !reset && load_s && (sel_s == SRC_B);

    mux16_arbiter_mux16 u_mux16 (
        .a   (a_data),
        .b   (b_data),
        .sel (sel_s),
        .y   (mux_y_s)
    );

    // Arbitration state, burst counter and output register; an accepted word
    // overwrites the register even while the old one drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            last_r      <= SRC_B;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
            out_src_r   <= SRC_A;
        end else if (xfer_s) begin
            out_data_r  <= mux_y_s;
            out_src_r   <= sel_s;
            out_valid_r <= 1'b1;
            last_r      <= sel_s;
            state_r     <= (sel_s == SRC_B) ? OWN_B : OWN_A;
            cnt_r       <= same_owner_s ? sat_inc(cnt_r) : 8'd1;
        end else begin
            if (go_idle_s) begin
                state_r <= IDLE;
                cnt_r   <= 8'd0;
            end else begin
                state_r <= state_r;
                cnt_r   <= cnt_r;
            end
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: doc/mux16_arbiter.md
# mux16_arbiter

Two-requester, 16-bit arbiter that shares a single Mux16 datapath between ports A and B and delivers one word per cycle into a registered output stage. It uses valid/ready handshakes on both input ports and on the output port. It applies round-robin priority with a bounded burst, so a streaming requester cannot starve the other. It sits between two data producers (for example, a CPU write path and a loader) and a single downstream 16-bit consumer.

## Interface
- BURST, 4: maximum consecutive transfers granted to one owner while the other port is waiting; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  port A presents a word.
- a_data  in  16  port A word.
- a_ready  out  1  port A word is accepted this cycle.
- b_valid  in  1  port B presents a word.
- b_data  in  16  port B word.
- b_ready  out  1  port B word is accepted this cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  16  output word.
- out_src  out  1  source of out_data: 0 = A, 1 = B.
- out_ready  in  1  consumer takes the word this cycle.

## Operation
- A transfer on port X occurs when X_valid and X_ready are both high on the same cycle.
- The output transfer occurs when out_valid and out_ready are both high.
- load = !out_valid || out_ready. The output register can accept a new word only when load = 1.
- Registered state:
  - state ∈ {IDLE, OWN_A, OWN_B}
  - cnt[7:0]: consecutive transfers by the current owner
  - last: source of the most recent transfer
- Choice of sel (0 = A, 1 = B) when load = 1:
  - IDLE, both valid: sel = !last.
  - IDLE, one valid: sel = that port.
  - IDLE, none valid: sel = last, no transfer.
  - OWN_X, X_valid && (cnt < BURST || !Y_valid): sel = X.
  - OWN_X, otherwise if Y_valid: sel = Y.
  - OWN_X, neither valid: no transfer, next state = IDLE, cnt = 0.
- Choice of sel when load = 0: sel = last, a_ready = b_ready = 0, and state and cnt hold.
- a_ready = load && sel == 0; b_ready = load && sel == 1. Both are 0 while reset is high.
- The data path is a Mux16 instance: a = a_data, b = b_data, sel = sel.
- On a transfer from X:
  - out_data ← mux output, out_src ← X, out_valid ← 1, last ← X.
  - state ← OWN_X.
  - cnt ← (previous owner == X) ? min(cnt + 1, 255) : 1.
- Output transfer with no new input transfer: out_valid ← 0. out_data and out_src hold their stale values.
- Output transfer and input transfer on the same cycle: the register is overwritten and out_valid stays 1 (full throughput).
- Reset values: out_valid = 0, out_data = 16'h0000, out_src = 0, state = IDLE, cnt = 0, last = 1 (A wins the first tie).
- Reset mid-operation discards the output word and the burst count immediately, with no handshake completion.

## Timing
- Input-to-output latency is 1 cycle: a word accepted at edge n is visible on out_data after edge n.
- Sustained throughput is 1 word/cycle when out_ready is held high.
- a_ready/b_ready are combinational from out_valid, out_ready, a_valid, b_valid and the registered state.
- There is no combinational path from a_data/b_data to any output.
- Backpressure: while out_valid && !out_ready, both readies are 0 and the output is stable.
- BURST = 1 degenerates to strict alternation whenever both ports are valid.
- A port that drops valid mid-burst forfeits ownership to a waiting port on the next load cycle.

## Structure
- Shared package: state encodings (IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2) and source constants SRC_A = 1'b0, SRC_B = 1'b1.
- One sub-module: the existing Mux16, instantiated for the data path. The arbitration FSM, counter and output register are in mux16_arbiter itself.

## Test plan
- Reset: assert reset mid-stream with out_valid = 1 → out_valid, out_data and cnt are 0 asynchronously, with no clock edge required; after release, a tie is granted to A.
- Solo streaming: a_valid = 1 continuously, a_data = 1, 2, 3…, b idle, out_ready = 1 → a_ready is high every cycle, out_data follows a_data one cycle later, out_src = 0, with no burst cutoff.
- Fairness, BURST = 4: both ports always valid, out_ready = 1 → out_src sequence A,A,A,A,B,B,B,B,A,…
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 and data 16'hBEEF → out_data holds BEEF, a_ready = b_ready = 0, cnt unchanged; releasing out_ready resumes with the same owner.
- Simultaneous output drain and input accept: out_valid = 1, out_ready = 1, b_valid = 1 with b_data = 16'h1234 → the next cycle shows out_valid = 1, out_data = 1234, out_src = 1.
- Owner drops valid: A owns with cnt = 2, a_valid goes low, b_valid = 1 → B is granted the same cycle and cnt becomes 1.
